// File: rtl/can_pkg.sv
// Shared definitions for the CAN transmit arbiter.
//   CAN_DW      : default payload width, equal to the can_controller DIN width
//   CAN_TIMEOUT : default cycle limit for any wait state before the frame is aborted
//   can_arb_state_t : arbiter FSM encoding
//   ptr_w()     : width of a requester index / round-robin pointer
package can_pkg;

  localparam int CAN_DW      = 108;
  localparam int CAN_TIMEOUT = 100000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } can_arb_state_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/can_tx_arbiter_if.sv
// Bus bundle between the requesters / can_controller and the arbiter.
//   REQ          : per-requester level request, held until its ACK or ERR
//   DATA         : flattened payloads, requester i at [i*DW +: DW]
//   GRANT        : one-hot owner of the transmitter, zero when idle
//   ACK / ERR    : one-cycle one-hot completion / abort pulse
//   CAN_DIN      : payload towards can_controller DIN
//   CAN_TX_START : one-cycle start pulse towards can_controller
//   CAN_TX_READY : can_controller idle indication
//   BUSY         : arbiter is not idle
// Modports: slave = arbiter side, master = requesters + controller side.
interface can_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = can_pkg::CAN_DW
) ();

  logic [N_REQ-1:0]    REQ;
  logic [N_REQ*DW-1:0] DATA;
  logic [N_REQ-1:0]    GRANT;
  logic [N_REQ-1:0]    ACK;
  logic [N_REQ-1:0]    ERR;
  logic [DW-1:0]       CAN_DIN;
  logic                CAN_TX_START;
  logic                CAN_TX_READY;
  logic                BUSY;

  modport slave (
    input  REQ, DATA, CAN_TX_READY,
    output GRANT, ACK, ERR, CAN_DIN, CAN_TX_START, BUSY
  );

  modport master (
    output REQ, DATA, CAN_TX_READY,
    input  GRANT, ACK, ERR, CAN_DIN, CAN_TX_START, BUSY
  );

endinterface

// File: rtl/can_arb_pick.sv
// Combinational winner search. Scans the requests starting at index ptr and
// wrapping N_REQ-1 -> 0; the first set request wins. With ptr tied to 0 this
// is plain fixed priority (lowest index wins).
//   req    : request vector
//   ptr    : search start index (must be < N_REQ)
//   winner : one-hot winner, zero when no request
//   valid  : at least one request present
module can_arb_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  // One extra bit so ptr + k never overflows before the wrap correction.
  localparam int SW = PW + 1;

  always_comb begin : search
    logic [SW-1:0] pos;
    winner = '0;
    valid  = 1'b0;
    pos    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = {1'b0, ptr} + SW'(k);
      if (pos >= SW'(N_REQ)) pos = pos - SW'(N_REQ);
      if (!valid && req[pos[PW-1:0]]) begin
        winner[pos[PW-1:0]] = 1'b1;
        valid               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/can_tx_arbiter.sv
// Shares one can_controller transmitter between N_REQ requesters.
//   GCLK      : clock, rising edge
//   RES       : synchronous active-low reset
//   bus       : can_tx_arbiter_if.slave (requests, payloads, controller link)
//   dbg_state : current FSM state
// Build option: define CAN_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority (lowest index wins) with no pointer register.
//
// Handshake: a requester raises REQ[i] (level) with DATA[i] valid and holds it
// until it sees ACK[i] or ERR[i]. The payload is captured into CAN_DIN at grant
// and GRANT/CAN_DIN stay frozen until the ACK/ERR pulse, so REQ/DATA changes in
// between are ignored (a dropped REQ does not abort the frame). A frame is
// launched only when CAN_TX_READY=1; the controller signals it has taken the
// frame by dropping CAN_TX_READY and completion by raising it again.
module can_tx_arbiter import can_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int DW      = CAN_DW,
  parameter int TIMEOUT = CAN_TIMEOUT
) (
  input  logic           GCLK,
  input  logic           RES,
  can_tx_arbiter_if.slave bus,
  output can_arb_state_t dbg_state
);

  localparam int PW = ptr_w(N_REQ);

  can_arb_state_t   state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic [DW-1:0]    din_q, din_d, din_sel;
  logic             start_q, start_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [PW-1:0]    ptr;
  logic [N_REQ-1:0] pick_onehot;
  logic             pick_valid;
  logic             timeout_hit;

`ifdef CAN_ARB_RR_EN
  logic [PW-1:0] ptr_q, ptr_d, owner_idx;

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant_q[i]) owner_idx = PW'(i);
  end

  // Pointer moves past the owner whenever its frame ends (ACK or ERR).
  always_comb begin
    ptr_d = ptr_q;
    if ((ack_d | err_d) != '0)
      ptr_d = (owner_idx == PW'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;
  end

  always_ff @(posedge GCLK) begin
    if (!RES) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  can_arb_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req    (bus.REQ),
    .ptr    (ptr),
    .winner (pick_onehot),
    .valid  (pick_valid)
  );

  always_comb begin
    din_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick_onehot[i]) din_sel = bus.DATA[i*DW +: DW];
  end

  // The counter holds 0..TIMEOUT-1 in a wait state; the cycle that would
  // bring it to TIMEOUT aborts instead.
  assign timeout_hit = (cnt_q == 32'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    ack_d   = '0;
    err_d   = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.CAN_TX_READY && pick_valid) begin
          state_d = START;
          grant_d = pick_onehot;
          din_d   = din_sel;
          // Registered so the pulse coincides with the START cycle.
          start_d = 1'b1;
        end
      end
      START: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: begin
        // Progress is checked before timeout so ACK and ERR never collide.
        if (!bus.CAN_TX_READY) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          err_d   = grant_q;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT_DONE: begin
        if (bus.CAN_TX_READY) begin
          ack_d   = grant_q;
          grant_d = '0;
          state_d = IDLE;
        end else if (timeout_hit) begin
          err_d   = grant_q;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge GCLK) begin
    if (!RES) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      din_q   <= '0;
      start_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      din_q   <= din_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.GRANT        = grant_q;
  assign bus.ACK          = ack_q;
  assign bus.ERR          = err_q;
  assign bus.CAN_DIN      = din_q;
  assign bus.CAN_TX_START = start_q;
  assign bus.BUSY         = (state_q != IDLE);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Directed bench for can_tx_arbiter. Instance dut_a uses the default timeout
// with a controller model that drops ready for 50 cycles after each start;
// instance dut_b uses TIMEOUT=20 with a controller that never drops ready.
module tb_can_tx_arbiter;
  import can_pkg::*;

  localparam int N        = 4;
  localparam int DW       = CAN_DW;
  localparam int SW       = N + DW;
  localparam int EW       = 2*N + DW;
  localparam int BUSY_CYC = 50;

  localparam logic [DW-1:0] D0     = 108'h4849;          // "HI"
  localparam logic [DW-1:0] D1     = 108'h0abc_1111;
  localparam logic [DW-1:0] D2     = 108'h0def_2222;
  localparam logic [DW-1:0] D3     = 108'h0123_3333_4444;
  localparam logic [DW-1:0] D2_NEW = 108'h0bad_0bad;
  localparam logic [DW-1:0] DB0    = 108'h5a5a;

  // ---------------- clock / reset ----------------
  logic GCLK = 1'b0;
  logic RES  = 1'b0;
  always #5 GCLK = ~GCLK;

  can_tx_arbiter_if #(.N_REQ(N), .DW(DW)) bus_a ();
  can_tx_arbiter_if #(.N_REQ(N), .DW(DW)) bus_b ();
  can_arb_state_t st_a, st_b;

  can_tx_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(CAN_TIMEOUT)) dut_a (
    .GCLK(GCLK), .RES(RES), .bus(bus_a), .dbg_state(st_a));

  can_tx_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(20)) dut_b (
    .GCLK(GCLK), .RES(RES), .bus(bus_b), .dbg_state(st_b));

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [SW-1:0] start_q_a[$];
  logic [EW-1:0] done_q_a[$];
  logic [EW-1:0] done_q_b[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_start(input logic [N-1:0] g, input logic [DW-1:0] d);
    start_q_a.push_back({g, d});
  endtask

  task automatic push_done(input logic [N-1:0] a, input logic [N-1:0] e, input logic [DW-1:0] d);
    done_q_a.push_back({a, e, d});
  endtask

  function automatic logic [DW-1:0] data_of(input int i);
    case (i)
      0: return D0;
      1: return D1;
      2: return D2;
      default: return D3;
    endcase
  endfunction

  // ---------------- requester model (dut_a) ----------------
  // want[i]: frames asked for by the sequence; got[i]: ACKs seen.
  int want[N];
  int got[N];

  always_comb begin
    bus_a.REQ = '0;
    for (int i = 0; i < N; i++) bus_a.REQ[i] = (want[i] > got[i]);
  end

  initial for (int i = 0; i < N; i++) got[i] = 0;
  always @(negedge GCLK)
    for (int i = 0; i < N; i++)
      if (bus_a.ACK[i]) got[i] = got[i] + 1;

  // ---------------- controller model (dut_a) ----------------
  logic ctl_ready = 1'b1;
  logic force_low = 1'b0;
  always_comb bus_a.CAN_TX_READY = ctl_ready & ~force_low;

  initial forever begin
    @(negedge GCLK);
    if (bus_a.CAN_TX_START) begin
      @(posedge GCLK);
      #1 ctl_ready = 1'b0;
      repeat (BUSY_CYC) @(posedge GCLK);
      #1 ctl_ready = 1'b1;
    end
  end

  // ---------------- monitors ----------------
  always @(negedge GCLK) begin : mon_a
    logic [SW-1:0] es;
    logic [EW-1:0] ed;
    if (bus_a.CAN_TX_START) begin
      if (start_q_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL start_unexpected: got start with grant %b, expected none", bus_a.GRANT);
      end else begin
        es = start_q_a.pop_front();
        check("start_grant_din", {bus_a.GRANT, bus_a.CAN_DIN}, es);
      end
    end
    if ((bus_a.ACK | bus_a.ERR) != '0) begin
      if (done_q_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL done_unexpected: got ack %b err %b, expected none", bus_a.ACK, bus_a.ERR);
      end else begin
        ed = done_q_a.pop_front();
        check("done_ack_err_din", {bus_a.ACK, bus_a.ERR, bus_a.CAN_DIN}, ed);
        check("done_grant_clear", bus_a.GRANT, 0);
      end
    end
  end

  always @(negedge GCLK) begin : mon_b
    logic [EW-1:0] ed;
    if ((bus_b.ACK | bus_b.ERR) != '0) begin
      if (done_q_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_done_unexpected: got ack %b err %b, expected none", bus_b.ACK, bus_b.ERR);
      end else begin
        ed = done_q_b.pop_front();
        check("b_done_ack_err_din", {bus_b.ACK, bus_b.ERR, bus_b.CAN_DIN}, ed);
      end
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_state_a(input can_arb_state_t s, input int budget, input string name);
    int n;
    n = 0;
    while (st_a !== s && n < budget) begin
      @(negedge GCLK);
      n++;
    end
    if (st_a !== s) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timed out, state %s expected %s", name, st_a.name(), s.name());
    end
  endtask

  task automatic drain_a(input string name);
    int n;
    n = 0;
    while ((start_q_a.size() != 0 || done_q_a.size() != 0 || st_a != IDLE) && n < 3000) begin
      @(negedge GCLK);
      n++;
    end
    check({name, "_pending"}, start_q_a.size() + done_q_a.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int ord[8];
    int n;

    for (int i = 0; i < N; i++) want[i] = 0;
    for (int i = 0; i < N; i++) bus_a.DATA[i*DW +: DW] = data_of(i);
    bus_b.DATA         = '0;
    bus_b.DATA[DW-1:0] = DB0;
    bus_b.REQ          = '0;
    bus_b.CAN_TX_READY = 1'b1;

    // Reset state
    RES = 1'b0;
    repeat (3) @(negedge GCLK);
    check("rst_grant", bus_a.GRANT, 0);
    check("rst_ack", bus_a.ACK, 0);
    check("rst_err", bus_a.ERR, 0);
    check("rst_start", bus_a.CAN_TX_START, 0);
    check("rst_busy", bus_a.BUSY, 0);
    check("rst_din", bus_a.CAN_DIN, 0);
    check("rst_state", st_a, IDLE);
    RES = 1'b1;
    repeat (2) @(negedge GCLK);

    // Single request: "HI" from requester 0
    push_start(4'b0001, D0);
    push_done(4'b0001, 4'b0000, D0);
    check("t1_no_start_before", bus_a.CAN_TX_START, 0);
    want[0] = 1;
    @(negedge GCLK);
    check("t1_start_latency", bus_a.CAN_TX_START, 1);
    check("t1_busy", bus_a.BUSY, 1);
    drain_a("t1");
    check("t1_idle_grant", bus_a.GRANT, 0);

    // Contention 1010: requester 1 then requester 3
    push_start(4'b0010, D1);
    push_done(4'b0010, 4'b0000, D1);
    push_start(4'b1000, D3);
    push_done(4'b1000, 4'b0000, D3);
    want[1] = want[1] + 1;
    want[3] = want[3] + 1;
    drain_a("t2");

    // All four request two frames each
`ifdef CAN_ARB_RR_EN
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
`else
    ord = '{0, 0, 1, 1, 2, 2, 3, 3};
`endif
    for (int k = 0; k < 8; k++) begin
      push_start(4'(1 << ord[k]), data_of(ord[k]));
      push_done(4'(1 << ord[k]), 4'b0000, data_of(ord[k]));
    end
    for (int i = 0; i < N; i++) want[i] = want[i] + 2;
    drain_a("t5");

    // Ready low in IDLE blocks the grant
    force_low = 1'b1;
    push_start(4'b0100, D2);
    push_done(4'b0100, 4'b0000, D2);
    want[2] = want[2] + 1;
    repeat (10) @(negedge GCLK);
    check("t3_no_grant", bus_a.GRANT, 0);
    check("t3_idle", st_a, IDLE);
    force_low = 1'b0;
    @(negedge GCLK);
    check("t3_grant_next", bus_a.GRANT, 4'b0100);
    drain_a("t3");

    // Mid-frame: owner drops REQ, its DATA changes, requester 0 raises REQ
    push_start(4'b0100, D2);
    push_done(4'b0100, 4'b0000, D2);
    push_start(4'b0001, D0);
    push_done(4'b0001, 4'b0000, D0);
    want[2] = want[2] + 1;
    @(negedge GCLK);
    wait_state_a(WAIT_DONE, 20, "t4_wait_done");
    want[2] = got[2];
    want[0] = want[0] + 1;
    bus_a.DATA[2*DW +: DW] = D2_NEW;
    repeat (3) @(negedge GCLK);
    check("t4_grant_stable", bus_a.GRANT, 4'b0100);
    check("t4_din_stable", bus_a.CAN_DIN, D2);
    drain_a("t4");

    // Reset during WAIT_DONE, request held throughout
    push_start(4'b0010, D1);
    push_start(4'b0010, D1);
    push_done(4'b0010, 4'b0000, D1);
    want[1] = want[1] + 1;
    @(negedge GCLK);
    wait_state_a(WAIT_DONE, 20, "t6_wait_done");
    RES = 1'b0;
    @(negedge GCLK);
    check("t6_grant", bus_a.GRANT, 0);
    check("t6_ack_err", {bus_a.ACK, bus_a.ERR}, 0);
    check("t6_start", bus_a.CAN_TX_START, 0);
    check("t6_busy", bus_a.BUSY, 0);
    check("t6_din", bus_a.CAN_DIN, 0);
    check("t6_state", st_a, IDLE);
    RES = 1'b1;
    drain_a("t6");

    // Timeout on dut_b: controller never leaves ready
    done_q_b.push_back({4'b0000, 4'b0001, DB0});
    bus_b.REQ = 4'b0001;
    n = 0;
    while (st_b !== WAIT_BUSY && n < 10) begin
      @(negedge GCLK);
      n++;
    end
    check("t7_reached_wait_busy", st_b, WAIT_BUSY);
    n = 0;
    while (bus_b.ERR == '0 && n < 100) begin
      @(negedge GCLK);
      n++;
    end
    bus_b.REQ = '0;
    check("t7_err_delay", n, 20);
    check("t7_state_idle", st_b, IDLE);
    check("t7_grant_clear", bus_b.GRANT, 0);
    repeat (3) @(negedge GCLK);
    check("t7_stays_idle", st_b, IDLE);

    // Final report
    repeat (2) @(negedge GCLK);
    check("end_start_q_a", start_q_a.size(), 0);
    check("end_done_q_a", done_q_a.size(), 0);
    check("end_done_q_b", done_q_b.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
